// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the byte-serial memory arbiter.
// A word is moved one byte per cycle, most significant byte first.
package mem_arb_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;
  localparam int ADDR_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_e;

  // Requester identity; also the encoding of last_grant.
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  function automatic logic [7:0] get_byte(input logic [WORD_W-1:0] w,
                                          input logic [1:0]        idx);
    case (idx)
      2'd0:    get_byte = w[31:24];
      2'd1:    get_byte = w[23:16];
      2'd2:    get_byte = w[15:8];
      default: get_byte = w[7:0];
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] put_byte(input logic [WORD_W-1:0] w,
                                                 input logic [1:0]        idx,
                                                 input logic [7:0]        b);
    put_byte = w;
    case (idx)
      2'd0:    put_byte[31:24] = b;
      2'd1:    put_byte[23:16] = b;
      2'd2:    put_byte[15:8]  = b;
      default: put_byte[7:0]   = b;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin choice: a lone request wins outright,
// a tie goes to the port that was not granted last.
module rr_arb2 import mem_arb_pkg::*; (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);

  always_comb begin
    grant = last_grant;
    case (req)
      2'b01:   grant = PORT_IF;
      2'b10:   grant = PORT_D;
      2'b11:   grant = ~last_grant;
      default: grant = last_grant;
    endcase
  end

endmodule

// File: rtl/byte_mem_arbiter.sv
// Shares one byte-wide memory between a fetch port and a data port,
// serialising each 32-bit word access into four big-endian byte cycles.
module byte_mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = WORD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              arb_grant;

  rr_arb2 u_rr_arb2 (
    .req        ({d_req, if_req}),
    .last_grant (last_grant_q),
    .grant      (arb_grant)
  );

  always_comb begin
    // NOTE: every _d and every output is defaulted first so no path leaves one unassigned (no latch).
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    base_d       = base_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_addr     = '0;
    mem_we       = 1'b0;
    mem_wdata    = '0;
    if_ack       = 1'b0;
    d_ack        = 1'b0;

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d      = XFER;
          cnt_d        = 2'd0;
          last_grant_d = arb_grant;
          if (arb_grant == PORT_D) begin
            base_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end else begin
            base_d  = if_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end
        end
      end

      XFER: begin
        // Address wraps naturally at the memory size.
        mem_addr  = base_q + ADDR_W'(cnt_q);
        mem_we    = we_q;
        mem_wdata = get_byte(wdata_q, cnt_q);
        if (!we_q) begin
          if (last_grant_q == PORT_D) d_rdata_d  = put_byte(d_rdata_q, cnt_q, mem_rdata);
          else                        if_rdata_d = put_byte(if_rdata_q, cnt_q, mem_rdata);
        end
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = DONE;
      end

      DONE: begin
        if_ack  = (last_grant_q == PORT_IF);
        d_ack   = (last_grant_q == PORT_D);
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      last_grant_q <= PORT_IF;
      base_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      base_q       <= base_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_byte_mem_arbiter.sv
// Directed bench for byte_mem_arbiter: a byte memory model plus a
// scoreboard of expected completions, checked with immediate assertions.
module tb_byte_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [4:0]  if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [4:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic [4:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  logic [7:0]  mem [32];
  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [7:0]  pl_data;

  typedef struct {
    logic        port;     // 0 = fetch, 1 = data
    logic        is_read;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          errors;
  int          last_we_cycles;
  logic [4:0]  addr_log [4];

  byte_mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory: DUT writes take priority over bench preloads.
  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr] <= mem_wdata;
    else if (pl_en) mem[pl_addr]  <= pl_data;
  end
  assign mem_rdata = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [4:0] a, input logic [7:0] b);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = b;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_acks"},     32'({if_ack, d_ack}), 32'd0);
    check({tag, "_mem_we"},   32'(mem_we),   32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_if_rdata"}, if_rdata,      32'd0);
    check({tag, "_d_rdata"},  d_rdata,       32'd0);
  endtask

  // Steps negedges until an ack appears; exp_lat counts negedges from the
  // call, so 5 when the request is sampled at the next edge, 6 when called
  // from a DONE cycle with the request still held.
  task automatic wait_done(input bit drop, input int exp_lat);
    exp_t e;
    bit   seen;
    int   xi;
    seen = 1'b0;
    last_we_cycles = 0;
    for (int k = 1; k <= 12 && !seen; k++) begin
      @(negedge clk);
      if (drop && k == 1) begin
        if_req  = 1'b0;
        d_req   = 1'b0;
        if_addr = 5'h1f;
        d_addr  = 5'h1f;
        d_we    = ~d_we;
        d_wdata = 32'hFFFF_FFFF;
      end
      xi = k - (exp_lat - 5);
      if (xi >= 1 && xi <= 4) addr_log[xi-1] = mem_addr;
      if (mem_we) last_we_cycles++;
      if (if_ack || d_ack) begin
        seen = 1'b1;
        check("ack_latency", 32'(k), 32'(exp_lat));
        check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("ack_pattern", 32'({if_ack, d_ack}), 32'({~e.port, e.port}));
          if (e.is_read)
            check(e.port ? "d_rdata" : "if_rdata", e.port ? d_rdata : if_rdata, e.data);
        end
      end
    end
    check("ack_seen", 32'(seen), 32'd1);
  endtask

  bit any_ack;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req  = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    pl_en  = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 32; i++) mem[i] = 8'h00;

    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;

    // Solo fetch, request dropped right after the latch edge.
    poke(5'd0, 8'h12); poke(5'd1, 8'h34); poke(5'd2, 8'h56); poke(5'd3, 8'h78);
    if_req = 1'b1; if_addr = 5'd0;
    sb.push_back('{port: 1'b0, is_read: 1'b1, data: 32'h1234_5678});
    wait_done(1'b1, 5);
    check("fetch_mem_we_cycles", 32'(last_we_cycles), 32'd0);
    @(negedge clk);
    check("fetch_idle_busy", 32'(busy), 32'd0);
    check("fetch_d_rdata_untouched", d_rdata, 32'd0);

    // Store; later port changes must not leak into the transfer.
    d_req = 1'b1; d_we = 1'b1; d_addr = 5'd8; d_wdata = 32'hAABB_CCDD;
    sb.push_back('{port: 1'b1, is_read: 1'b0, data: 32'h0});
    wait_done(1'b1, 5);
    check("store_mem_we_cycles", 32'(last_we_cycles), 32'd4);
    check("store_bytes", {mem[8], mem[9], mem[10], mem[11]}, 32'hAABB_CCDD);
    @(negedge clk);
    check("store_ack_single", 32'({if_ack, d_ack}), 32'd0);
    check("store_neighbour", 32'({mem[7], mem[12]}), 32'd0);

    // Load wrapping past the top of memory.
    poke(5'd30, 8'h01); poke(5'd31, 8'h02); poke(5'd0, 8'h03); poke(5'd1, 8'h04);
    d_req = 1'b1; d_we = 1'b0; d_addr = 5'd30;
    sb.push_back('{port: 1'b1, is_read: 1'b1, data: 32'h0102_0304});
    wait_done(1'b1, 5);
    check("wrap_addr_seq", {3'b0, addr_log[0], 3'b0, addr_log[1], 3'b0, addr_log[2], 3'b0, addr_log[3]},
          {8'd30, 8'd31, 8'd0, 8'd1});
    check("wrap_if_rdata_held", if_rdata, 32'h1234_5678);

    // Tie with both requests held: data, fetch, data.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    poke(5'd4, 8'h11);  poke(5'd5, 8'h22);  poke(5'd6, 8'h33);  poke(5'd7, 8'h44);
    poke(5'd12, 8'h55); poke(5'd13, 8'h66); poke(5'd14, 8'h77); poke(5'd15, 8'h88);
    if_req = 1'b1; if_addr = 5'd12;
    d_req  = 1'b1; d_we = 1'b0; d_addr = 5'd4;
    sb.push_back('{port: 1'b1, is_read: 1'b1, data: 32'h1122_3344});
    sb.push_back('{port: 1'b0, is_read: 1'b1, data: 32'h5566_7788});
    sb.push_back('{port: 1'b1, is_read: 1'b1, data: 32'h1122_3344});
    wait_done(1'b0, 5);
    wait_done(1'b0, 6);
    wait_done(1'b0, 6);
    if_req = 1'b0; d_req = 1'b0;
    check("tie_sb_drained", 32'(sb.size()), 32'd0);
    @(negedge clk);

    // Reset in the middle of a store, at cnt = 2.
    d_req = 1'b1; d_we = 1'b1; d_addr = 5'd0; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    d_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst_pre_addr", 32'(mem_addr), 32'd2);
    check("midrst_pre_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    check("midrst_partial_bytes", {mem[0], mem[1], mem[2], mem[3]}, 32'hDEAD_5678);
    rst_n = 1'b1;
    any_ack = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (if_ack || d_ack || busy) any_ack = 1'b1;
    end
    check("midrst_no_ack", 32'(any_ack), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_mem_arbiter.md
BYTE_MEM_ARBITER -- requirements
Module: byte_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, byte-address width of the shared memory (32 bytes).
REQ-002 SHALL have parameter DATA_W, default 32, word width seen by requesters; fixed at 4 bytes.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1, rising-edge clock for all state.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port if_req, input, 1, instruction-fetch word read request.
REQ-007 SHALL have port if_addr, input, ADDR_W, fetch byte address (pc[4:0]).
REQ-008 SHALL have port if_ack, output, 1, one-cycle pulse; if_rdata valid in the same cycle.
REQ-009 SHALL have port if_rdata, output, 32, fetched word, big-endian.
REQ-010 SHALL have port d_req, input, 1, data-port word request.
REQ-011 SHALL have port d_we, input, 1, 1 = store, 0 = load.
REQ-012 SHALL have port d_addr, input, ADDR_W, data byte address (ALU sum).
REQ-013 SHALL have port d_wdata, input, 32, store word.
REQ-014 SHALL have port d_ack, output, 1, one-cycle completion pulse.
REQ-015 SHALL have port d_rdata, output, 32, load word, big-endian.
REQ-016 SHALL have port mem_addr, output, ADDR_W, shared byte-memory address.
REQ-017 SHALL have port mem_we, output, 1, byte write strobe.
REQ-018 SHALL have port mem_wdata, output, 8, byte to write.
REQ-019 SHALL have port mem_rdata, input, 8, combinational read byte at mem_addr.
REQ-020 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-021 SHALL implement states IDLE, XFER and DONE, with a 2-bit byte counter cnt.
REQ-022 SHALL, in IDLE with any request, latch winner, address, we and wdata at the edge and enter XFER with cnt=0.
REQ-023 SHALL arbitrate round-robin: if both requests are high, grant the port not granted last; last_grant resets to fetch, so data wins the first tie.
REQ-024 SHALL, in XFER, drive mem_addr = (base + cnt) mod 2^ADDR_W; a transfer at base 30 accesses bytes 30, 31, 0 and 1.
REQ-025 SHALL order bytes big-endian: cnt=0 maps to word[31:24] and cnt=3 maps to word[7:0].
REQ-026 SHALL, for a read, capture mem_rdata into word byte cnt at each XFER edge.
REQ-027 SHALL, for a write, drive mem_we=1 and mem_wdata = wdata byte cnt during every XFER cycle; mem_we SHALL be 0 in all other states and for reads.
REQ-028 SHALL increment cnt each XFER cycle and move to DONE after cnt=3.
REQ-029 SHALL hold the granted ack high for exactly the DONE cycle, then return to IDLE.
REQ-030 SHALL hold the ungranted ack low throughout.
REQ-031 SHALL produce the ack in the 5th cycle after the sampling edge; one word occupies 6 cycles end to end.
REQ-032 SHALL hold if_rdata and d_rdata at their last captured values until the next read on that port.
REQ-033 SHALL ignore request, address and data changes after the latch edge; a request dropped mid-transfer still completes and still acks.
REQ-034 SHALL issue a new grant when a requester holds req high across DONE (pipelined reuse).
REQ-035 SHALL drive mem_addr as 0 when no transfer is in progress (IDLE and DONE).

Reset
REQ-036 SHALL, on rst_n low, immediately force state IDLE, cnt 0, last_grant fetch, mem_we 0, both acks 0, both rdata 0 and busy 0, including mid-XFER.
REQ-037 SHALL leave any interrupted write partially applied; no rollback.

Structure
REQ-038 SHALL take the state enum, BYTES_PER_WORD=4 and the default ADDR_W from shared package mem_arb_pkg.
REQ-039 SHALL place the two-requester round-robin decision in sub-module rr_arb2 (inputs req[1:0] and last_grant; output grant).

Verification
REQ-040 SHALL cover a solo fetch: mem bytes 0..3 = 12 34 56 78, if_req at addr 0 -> if_ack in cycle 5, if_rdata=12345678.
REQ-041 SHALL cover a store: d_we=1, d_addr=8, d_wdata=AABBCCDD -> mem bytes 8..11 = AA BB CC DD, mem_we high for exactly 4 cycles, d_ack pulses once.
REQ-042 SHALL cover a wrap: load at d_addr=30 with bytes 30,31,0,1 = 01 02 03 04 -> d_rdata=01020304.
REQ-043 SHALL cover a tie with both requests held high -> data is granted first, then fetch, then data, alternating.
REQ-044 SHALL cover reset mid-XFER: rst_n low at cnt=2 of a store -> mem_we drops at once, state IDLE, only bytes 0-1 written, no ack.
